// File: rtl/uart_core.sv
// Full-duplex UART with a compile-time frame format (data bits, parity, stop bits)
// and a show-ahead receive FIFO that reports overruns.
module uart_core #(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [DATA_BITS-1:0] uart_in,
    input  logic                 uart_in_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] uart_out,
    output logic                 uart_out_perr,
    output logic                 uart_out_valid,
    input  logic                 uart_out_ready,
    output logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 RxD,
    output logic                 TxD
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(RX_FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY == 1);
    localparam logic          HAS_PAR   = (PARITY != 0);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    tx_state_t            r_tx_state, w_tx_state_nxt;
    logic [CW-1:0]        r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0]           r_tx_bit, w_tx_bit_nxt;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nxt;
    logic                 r_tx_par, w_tx_par_nxt;
    logic                 r_txd, w_txd_nxt;
    logic                 w_tx_tick;

    rx_state_t            r_rx_state, w_rx_state_nxt;
    logic [CW-1:0]        r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0]           r_rx_bit, w_rx_bit_nxt;
    logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_nxt;
    logic                 r_rx_par_bit, w_rx_par_bit_nxt;
    logic                 r_rx_meta, r_rx_sync;
    logic                 w_rx, w_rx_tick, w_rx_perr;
    logic                 w_fifo_wr, w_fe_set;

    logic [DATA_BITS-1:0] r_fifo_data [RX_FIFO_DEPTH];
    logic [RX_FIFO_DEPTH-1:0] r_fifo_perr;
    logic [AW:0]          r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic                 r_out_valid, r_rx_ready, r_frame_err, r_overrun;
    logic                 w_pop, w_push, w_full, w_ovr;

    // ---------------- transmitter ----------------
    assign w_tx_tick = (r_tx_cnt == '0);

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = w_tx_tick ? BIT_LAST : r_tx_cnt - 1'b1;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_par_nxt   = r_tx_par;
        w_txd_nxt      = 1'b1;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_nxt = BIT_LAST;
                if (uart_in_valid) begin
                    w_tx_state_nxt = TX_START;
                    w_tx_shift_nxt = uart_in;
                    w_tx_par_nxt   = (^uart_in) ^ ODD;
                end
            end
            TX_START: if (w_tx_tick) begin
                w_tx_state_nxt = TX_DATA;
                w_tx_bit_nxt   = DATA_LAST;
            end
            TX_DATA: if (w_tx_tick) begin
                if (r_tx_bit == '0) begin
                    w_tx_state_nxt = HAS_PAR ? TX_PARITY : TX_STOP;
                    w_tx_bit_nxt   = STOP_LAST;
                end else begin
                    w_tx_bit_nxt   = r_tx_bit - 1'b1;
                    w_tx_shift_nxt = r_tx_shift >> 1;
                end
            end
            TX_PARITY: if (w_tx_tick) begin
                w_tx_state_nxt = TX_STOP;
                w_tx_bit_nxt   = STOP_LAST;
            end
            TX_STOP: if (w_tx_tick) begin
                if (r_tx_bit == '0) w_tx_state_nxt = TX_IDLE;
                else                w_tx_bit_nxt   = r_tx_bit - 1'b1;
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
        // TxD is registered from the next state so the pin never glitches
        case (w_tx_state_nxt)
            TX_START:  w_txd_nxt = 1'b0;
            TX_DATA:   w_txd_nxt = w_tx_shift_nxt[0];
            TX_PARITY: w_txd_nxt = w_tx_par_nxt;
            default:   w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_par   <= w_tx_par_nxt;
            r_txd      <= w_txd_nxt;
        end
    end

    assign TxD      = r_txd;
    assign tx_ready = (r_tx_state == TX_IDLE);

    // ---------------- receiver ----------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= RxD;
            r_rx_sync <= r_rx_meta;
        end
    end

    assign w_rx      = r_rx_sync;
    assign w_rx_tick = (r_rx_cnt == '0);
    assign w_rx_perr = HAS_PAR & (r_rx_par_bit != ((^r_rx_shift) ^ ODD));

    always_comb begin
        w_rx_state_nxt   = r_rx_state;
        w_rx_cnt_nxt     = w_rx_tick ? BIT_LAST : r_rx_cnt - 1'b1;
        w_rx_bit_nxt     = r_rx_bit;
        w_rx_shift_nxt   = r_rx_shift;
        w_rx_par_bit_nxt = r_rx_par_bit;
        w_fifo_wr        = 1'b0;
        w_fe_set         = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_nxt = HALF_LAST;
                if (!w_rx) w_rx_state_nxt = RX_START;
            end
            RX_START: if (w_rx_tick) begin
                if (w_rx) begin
                    w_rx_state_nxt = RX_IDLE;
                end else begin
                    w_rx_state_nxt = RX_DATA;
                    w_rx_bit_nxt   = DATA_LAST;
                end
            end
            RX_DATA: if (w_rx_tick) begin
                w_rx_shift_nxt = {w_rx, r_rx_shift[DATA_BITS-1:1]};
                if (r_rx_bit == '0) w_rx_state_nxt = HAS_PAR ? RX_PARITY : RX_STOP;
                else                w_rx_bit_nxt   = r_rx_bit - 1'b1;
            end
            RX_PARITY: if (w_rx_tick) begin
                w_rx_par_bit_nxt = w_rx;
                w_rx_state_nxt   = RX_STOP;
            end
            RX_STOP: if (w_rx_tick) begin
                if (w_rx) begin
                    w_fifo_wr      = 1'b1;
                    w_rx_state_nxt = RX_IDLE;
                end else begin
                    w_fe_set       = 1'b1;
                    w_rx_state_nxt = RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: if (w_rx) w_rx_state_nxt = RX_IDLE;
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rx_state   <= RX_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_par_bit <= 1'b0;
        end else begin
            r_rx_state   <= w_rx_state_nxt;
            r_rx_cnt     <= w_rx_cnt_nxt;
            r_rx_bit     <= w_rx_bit_nxt;
            r_rx_shift   <= w_rx_shift_nxt;
            r_rx_par_bit <= w_rx_par_bit_nxt;
        end
    end

    // ---------------- receive FIFO ----------------
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign w_pop  = r_out_valid & uart_out_ready;
    assign w_full = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push = w_fifo_wr & (~w_full | w_pop);
    assign w_ovr  = w_fifo_wr & w_full & ~w_pop;
    assign w_wr_ptr_nxt = r_wr_ptr + {{AW{1'b0}}, w_push};
    assign w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < RX_FIFO_DEPTH; i++) r_fifo_data[i] <= '0;
            r_fifo_perr <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_rx_ready  <= 1'b1;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr[AW-1:0]] <= r_rx_shift;
                r_fifo_perr[r_wr_ptr[AW-1:0]] <= w_rx_perr;
            end
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_out_valid <= (w_wr_ptr_nxt != w_rd_ptr_nxt);
            r_rx_ready  <= !((w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                             (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]));
            r_frame_err <= w_fe_set;
            r_overrun   <= w_ovr;
        end
    end

    assign uart_out       = r_fifo_data[r_rd_ptr[AW-1:0]];
    assign uart_out_perr  = r_fifo_perr[r_rd_ptr[AW-1:0]];
    assign uart_out_valid = r_out_valid;
    assign rx_ready       = r_rx_ready;
    assign frame_err      = r_frame_err;
    assign overrun        = r_overrun;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench: instance A is 8N1 (loopback capable), instance B is 7E2; both 16 clocks per bit.
module tb_uart_core;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    // instance A: 8N1
    logic [7:0] in_a = '0;
    logic       valid_a = 1'b0, ready_a = 1'b0, drv_a = 1'b1, loop_a = 1'b0;
    logic       tx_ready_a, out_valid_a, out_perr_a, rx_ready_a, fe_a, ov_a, txd_a, rxd_a;
    logic [7:0] out_a;
    assign rxd_a = loop_a ? txd_a : drv_a;

    // instance B: 7E2
    logic [6:0] in_b = '0;
    logic       valid_b = 1'b0, ready_b = 1'b0, drv_b = 1'b1;
    logic       tx_ready_b, out_valid_b, out_perr_b, rx_ready_b, fe_b, ov_b, txd_b;
    logic [6:0] out_b;

    uart_core #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .RX_FIFO_DEPTH(4)) dut_a (
        .clk(clk), .n_rst(n_rst), .uart_in(in_a), .uart_in_valid(valid_a), .tx_ready(tx_ready_a),
        .uart_out(out_a), .uart_out_perr(out_perr_a), .uart_out_valid(out_valid_a),
        .uart_out_ready(ready_a), .rx_ready(rx_ready_a), .frame_err(fe_a), .overrun(ov_a),
        .RxD(rxd_a), .TxD(txd_a));

    uart_core #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(2),
                .STOP_BITS(2), .RX_FIFO_DEPTH(4)) dut_b (
        .clk(clk), .n_rst(n_rst), .uart_in(in_b), .uart_in_valid(valid_b), .tx_ready(tx_ready_b),
        .uart_out(out_b), .uart_out_perr(out_perr_b), .uart_out_valid(out_valid_b),
        .uart_out_ready(ready_b), .rx_ready(rx_ready_b), .frame_err(fe_b), .overrun(ov_b),
        .RxD(drv_b), .TxD(txd_b));

    int checks = 0, errors = 0;
    int fe_cnt_a = 0, ov_cnt_a = 0, fe_cnt_b = 0;

    always @(negedge clk) begin
        if (fe_a === 1'b1) fe_cnt_a++;
        if (ov_a === 1'b1) ov_cnt_a++;
        if (fe_b === 1'b1) fe_cnt_b++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int sel, input logic b);
        if (sel == 0) drv_a = b;
        else          drv_b = b;
    endtask

    task automatic rx_frame(input int sel, input logic [7:0] data, input int nbits,
                            input bit use_par, input logic par_bit, input logic stop);
        drive(sel, 1'b0); tick(CPB);
        for (int i = 0; i < nbits; i++) begin
            drive(sel, data[i]); tick(CPB);
        end
        if (use_par) begin
            drive(sel, par_bit); tick(CPB);
        end
        drive(sel, stop); tick(CPB);
        drive(sel, 1'b1);
    endtask

    task automatic pop_a(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, out_valid_a, 1);
        chk({tag, "_data"}, out_a, exp);
        ready_a = 1'b1; tick(1); ready_a = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  exp_a;
        logic [10:0] exp_b;
        int fe0, ov0;
        bit stop_ok;
        exp_a = 10'b1101001010;
        exp_b = 11'b11100001110;

        // reset state
        tick(3);
        chk("rst_txd", txd_a, 1);
        chk("rst_tx_ready", tx_ready_a, 1);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_rx_ready", rx_ready_a, 1);
        chk("rst_out", out_a, 0);
        chk("rst_perr", out_perr_a, 0);
        chk("rst_fe_ov", {fe_a, ov_a}, 0);
        n_rst = 1'b1;
        tick(4);

        // loopback 8N1, 0xA5; a late valid with other data must be ignored
        loop_a = 1'b1;
        in_a = 8'hA5; valid_a = 1'b1;
        tick(1);
        valid_a = 1'b0;
        chk("a_busy_c1", tx_ready_a, 0);
        for (int c = 1; c <= 161; c++) begin
            if (c > 1) tick(1);
            if (c == 30) begin in_a = 8'h00; valid_a = 1'b1; end
            if (c == 100) valid_a = 1'b0;
            if (((c - 1) % CPB == 8) && c <= 160)
                chk($sformatf("a_txbit%0d", (c - 1) / CPB), txd_a, exp_a[(c - 1) / CPB]);
            if (c == 160) chk("a_ready_c160", tx_ready_a, 0);
            if (c == 161) chk("a_ready_c161", tx_ready_a, 1);
        end
        chk("a_loop_perr", out_perr_a, 0);
        pop_a("a_loop", 8'hA5);
        chk("a_loop_empty", out_valid_a, 0);
        loop_a = 1'b0;
        tick(4);

        // 7E2 transmit of 0x07: parity 1, two stop bits
        in_b = 7'h07; valid_b = 1'b1;
        tick(1);
        valid_b = 1'b0;
        stop_ok = 1'b1;
        for (int c = 1; c <= 177; c++) begin
            if (c > 1) tick(1);
            if (((c - 1) % CPB == 8) && c <= 176)
                chk($sformatf("b_txbit%0d", (c - 1) / CPB), txd_b, exp_b[(c - 1) / CPB]);
            if (c >= 145 && c <= 176 && txd_b !== 1'b1) stop_ok = 1'b0;
            if (c == 176) chk("b_ready_c176", tx_ready_b, 0);
            if (c == 177) chk("b_ready_c177", tx_ready_b, 1);
        end
        chk("b_stop_high_32", stop_ok, 1);

        // 7E2 receive: wrong then right parity
        rx_frame(1, 8'h07, 7, 1'b1, 1'b0, 1'b1);
        tick(4);
        chk("b_rx_valid", out_valid_b, 1);
        chk("b_rx_data", out_b, 7'h07);
        chk("b_rx_perr1", out_perr_b, 1);
        ready_b = 1'b1; tick(1); ready_b = 1'b0;
        rx_frame(1, 8'h07, 7, 1'b1, 1'b1, 1'b1);
        tick(4);
        chk("b_rx2_data", out_b, 7'h07);
        chk("b_rx2_perr0", out_perr_b, 0);
        ready_b = 1'b1; tick(1); ready_b = 1'b0;
        chk("b_empty", out_valid_b, 0);
        chk("b_no_fe", fe_cnt_b, 0);

        // frame error then clean frame
        fe0 = fe_cnt_a;
        rx_frame(0, 8'h3C, 8, 1'b0, 1'b0, 1'b0);
        tick(4 * CPB);
        chk("fe_pulses", fe_cnt_a - fe0, 1);
        chk("fe_no_write", out_valid_a, 0);
        rx_frame(0, 8'h11, 8, 1'b0, 1'b0, 1'b1);
        tick(4);
        pop_a("fe_next", 8'h11);

        // overrun with FIFO depth 4
        ov0 = ov_cnt_a;
        for (int i = 1; i <= 4; i++) rx_frame(0, 8'(i), 8, 1'b0, 1'b0, 1'b1);
        chk("ov_full_rx_ready", rx_ready_a, 0);
        chk("ov_none_yet", ov_cnt_a - ov0, 0);
        rx_frame(0, 8'h05, 8, 1'b0, 1'b0, 1'b1);
        tick(2);
        chk("ov_pulse", ov_cnt_a - ov0, 1);
        for (int i = 1; i <= 4; i++) pop_a($sformatf("ov_pop%0d", i), 8'(i));
        chk("ov_empty", out_valid_a, 0);
        chk("ov_rx_ready_back", rx_ready_a, 1);

        // coincident pop with the fifth write
        ov0 = ov_cnt_a;
        for (int i = 1; i <= 4; i++) rx_frame(0, 8'(i), 8, 1'b0, 1'b0, 1'b1);
        chk("cp_full", rx_ready_a, 0);
        fork
            rx_frame(0, 8'h05, 8, 1'b0, 1'b0, 1'b1);
            begin
                tick(154);
                chk("cp_head", out_a, 8'h01);
                ready_a = 1'b1; tick(1); ready_a = 1'b0;
            end
        join
        tick(2);
        chk("cp_no_overrun", ov_cnt_a - ov0, 0);
        chk("cp_still_full", rx_ready_a, 0);
        for (int i = 2; i <= 5; i++) pop_a($sformatf("cp_pop%0d", i), 8'(i));
        chk("cp_empty", out_valid_a, 0);

        // short glitch is rejected
        fe0 = fe_cnt_a;
        drv_a = 1'b0; tick(5); drv_a = 1'b1;
        tick(20 * CPB);
        chk("glitch_no_fe", fe_cnt_a - fe0, 0);
        chk("glitch_no_write", out_valid_a, 0);

        // asynchronous reset mid-TX and mid-RX data bit, with one byte queued
        rx_frame(0, 8'h42, 8, 1'b0, 1'b0, 1'b1);
        tick(2);
        chk("rst_pre_valid", out_valid_a, 1);
        fe0 = fe_cnt_a; ov0 = ov_cnt_a;
        in_a = 8'h5A; valid_a = 1'b1; drv_a = 1'b0;
        tick(1);
        valid_a = 1'b0;
        tick(15);
        drv_a = 1'b1;
        tick(8);
        chk("rst_pre_txd", txd_a, 0);
        chk("rst_pre_busy", tx_ready_a, 0);
        n_rst = 1'b0;
        #1;
        chk("rst_mid_txd", txd_a, 1);
        chk("rst_mid_tx_ready", tx_ready_a, 1);
        chk("rst_mid_valid", out_valid_a, 0);
        chk("rst_mid_rx_ready", rx_ready_a, 1);
        tick(3);
        n_rst = 1'b1;
        tick(20 * CPB);
        chk("rst_post_fe", fe_cnt_a - fe0, 0);
        chk("rst_post_ov", ov_cnt_a - ov0, 0);
        chk("rst_post_valid", out_valid_a, 0);
        chk("rst_post_txd", txd_a, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_core.md
# uart_core

Parametrised full-duplex UART: one transmitter and one receiver with compile-time frame format (data width, parity mode, stop-bit count) and a receive FIFO with overrun detection. Sits between the board pins RxD/TxD and on-chip byte-stream logic. It replaces the fixed 8N1 UART pair wherever parity, non-8-bit frames or receive buffering are required.

## Interface
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- BAUD_RATE, 115_200, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer divide, must be >= 8)
- DATA_BITS, 8, data bits per frame, legal 5..8
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, legal 1 or 2
- RX_FIFO_DEPTH, 4, receive FIFO entries, power of two, >= 2
- clk  in  1  system clock; all logic on the rising edge
- n_rst  in  1  asynchronous active-low reset
- uart_in  in  DATA_BITS  byte to transmit
- uart_in_valid  in  1  uart_in is valid
- tx_ready  out  1  transmitter idle; a byte is accepted when uart_in_valid && tx_ready
- uart_out  out  DATA_BITS  head of the RX FIFO
- uart_out_perr  out  1  parity error flag stored with the head entry (always 0 when PARITY = 0)
- uart_out_valid  out  1  RX FIFO not empty
- uart_out_ready  in  1  consumer pop; the head is removed when uart_out_valid && uart_out_ready
- rx_ready  out  1  RX FIFO not full
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: received byte dropped because the FIFO was full
- RxD  in  1  serial input, asynchronous to clk
- TxD  out  1  serial output, idle high

## Operation
- Reset values: TxD = 1, tx_ready = 1, uart_out_valid = 0, rx_ready = 1, uart_out = 0, uart_out_perr = 0, frame_err = 0, overrun = 0; FIFO empty; both FSMs in IDLE; the RxD synchroniser flops are reset to 1.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped when PARITY = 0) -> STOP -> IDLE. uart_in is latched on acceptance. Data is sent LSB first. The parity bit is the XOR of the data bits, inverted for odd parity. STOP lasts STOP_BITS bit periods at level 1.
- uart_in_valid is ignored while tx_ready = 0. Changes on uart_in after acceptance have no effect on the frame in progress.
- RX input passes through a 2-flop synchroniser. RX FSM: IDLE -> START -> DATA -> PARITY (skipped when PARITY = 0) -> STOP -> IDLE, plus a WAIT_HIGH state.
- IDLE: a synchronised low starts the CLKS_PER_BIT/2 count.
- START: at the half-bit point the line is re-sampled. If it is high, the event is a glitch and the FSM returns to IDLE with no output.
- DATA and PARITY: each bit is sampled once, every CLKS_PER_BIT cycles after the start-bit mid-point.
- STOP: only the first stop bit is sampled, even when STOP_BITS = 2.
  - Stop bit high: the byte is written to the FIFO with perr = (parity mismatch), then IDLE.
  - Stop bit low: frame_err pulses, nothing is written, then WAIT_HIGH. WAIT_HIGH returns to IDLE on the first synchronised high.
- FIFO write when full: the data is dropped, overrun pulses, and FIFO contents are unchanged.
- FIFO pop and write in the same cycle are both honoured. This also holds when the FIFO is full, since the pop frees a slot and no overrun occurs.
- Pointers are log2(RX_FIFO_DEPTH)+1 bits and wrap naturally. The extra MSB distinguishes full from empty.

## Timing
- TX: the acceptance edge is cycle 0. tx_ready = 0 and TxD = 0 from cycle 1. Each bit is held for exactly CLKS_PER_BIT cycles. tx_ready returns to 1 in the cycle after the last stop-bit period ends. This gives a back-to-back frame period of (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT + 1 cycles.
- RX: uart_out_valid rises one cycle after the stop-bit sample cycle when the FIFO was empty. The FIFO is show-ahead, so uart_out and uart_out_perr are valid whenever uart_out_valid = 1.
- rx_ready and uart_out_valid are registered and update the cycle after the write or pop that changes occupancy.
- frame_err and overrun assert in the cycle after the stop-bit sample, for exactly one cycle.
- Asynchronous reset mid-frame behaves as follows:
  - TxD returns to 1 immediately and the frame is truncated.
  - The RX FSM aborts, the FIFO is cleared, and no error pulse is produced.
  - After reset deassertion, a line held low is treated as a new start bit only after a synchronised high-to-low transition, because the synchroniser resets to 1.

## Test plan
- Loopback (TxD tied to RxD), 8N1, CLKS_PER_BIT = 434, send 0xA5 -> TxD shows 0,1,0,1,0,0,1,0,1,1 at 434-cycle spacing; uart_out = 0xA5, perr = 0; tx_ready high 4341 cycles after acceptance.
- PARITY = 2, DATA_BITS = 7: send 0x07 -> parity bit on TxD = 1. Drive RxD with 0x07 and parity bit 0 -> uart_out = 0x07, uart_out_perr = 1.
- Frame error: drive RxD with 0x3C and the stop bit low -> frame_err pulses once, uart_out_valid stays 0; the next valid frame 0x11 is received correctly.
- Overrun, RX_FIFO_DEPTH = 4, uart_out_ready = 0: receive 0x01..0x05 -> rx_ready = 0 after the 4th byte, overrun pulses on the 5th, and pops return 0x01..0x04 in order. Repeat with a pop coincident with the 5th write -> no overrun, and 0x05 is retained.
- Glitch: a 100-cycle low pulse on RxD -> no FIFO write and no frame_err. Also check STOP_BITS = 2 on TX -> TxD high for 868 cycles before tx_ready.
- Reset: assert n_rst mid-TX and mid-RX data bit -> TxD = 1 and tx_ready = 1 at once, FIFO empty, and no error pulses after release.
